// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types, constants and address helper for the instruction-memory responder
package imem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_e;

   localparam logic [31:0] INST_ERR_FILL = 32'h0000_0000;

   // Unsigned wrap below base makes the offset huge, so it also fails the bound.
   function automatic logic addr_in_range(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input int unsigned depth);
      logic [31:0] off;
      off = addr - base;
      return off < (depth * 4);
   endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - word-organised instruction storage, one sync read port and one sync write port
module imem_array #(
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
   input  logic          clk_i,
   input  logic          rd_en_i,
   input  logic [AW-1:0] rd_idx_i,
   output logic [31:0]   rd_data_o,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_idx_i,
   input  logic [31:0]   wr_data_i
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rd_data_q;

   // Both ports update with non-blocking assignments, so a same-edge read sees the old word.
   always_ff @(posedge clk_i) begin
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_idx_i];
      end
      if (wr_en_i) begin
         mem_q[wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fetch responder: address decode, latency FSM and backdoor load over imem_array
module imem_responder
   import imem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned LATENCY     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_inst,
   output logic        rsp_err,
   input  logic        load_en,
   input  logic [31:0] load_addr,
   input  logic [31:0] load_data,
   output logic        busy
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic        req_ready_q;
   logic        rsp_valid_q;
   logic        err_q;
   logic        have_data_q;

   logic [31:0] req_off;
   logic [31:0] load_off;
   logic        req_err_d;
   logic        load_ok_d;
   logic        accept;
   logic [31:0] rd_data;
   logic        unused_addr_bits;

   always_comb begin
      req_off   = req_addr - BASE_ADDR;
      load_off  = load_addr - BASE_ADDR;
      req_err_d = (req_addr[1:0] != 2'b00) || !addr_in_range(req_addr, BASE_ADDR, DEPTH_WORDS);
      load_ok_d = (load_addr[1:0] == 2'b00) && addr_in_range(load_addr, BASE_ADDR, DEPTH_WORDS);
   end

   assign accept = req_valid && req_ready_q;
   assign unused_addr_bits = ^{req_off[31:AW+2], req_off[1:0], load_off[31:AW+2], load_off[1:0]};

   imem_array #(
      .DEPTH_WORDS(DEPTH_WORDS),
      .AW         (AW)
   ) u_array (
      .clk_i    (clk),
      .rd_en_i  (accept && !req_err_d),
      .rd_idx_i (req_off[AW+1:2]),
      .rd_data_o(rd_data),
      .wr_en_i  (load_en && load_ok_d),
      .wr_idx_i (load_off[AW+1:2]),
      .wr_data_i(load_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         err_q       <= 1'b0;
         have_data_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  err_q       <= req_err_d;
                  have_data_q <= 1'b1;
                  req_ready_q <= 1'b0;
                  if (LATENCY == 1) begin
                     state_q     <= RESP;
                     rsp_valid_q <= 1'b1;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= 4'(LATENCY - 1);
                  end
               end
            end
            WAIT: begin
               if (cnt_q == 4'd1) begin
                  state_q     <= RESP;
                  rsp_valid_q <= 1'b1;
                  cnt_q       <= 4'd0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  state_q     <= IDLE;
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= IDLE;
               req_ready_q <= 1'b1;
               rsp_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // The array output only moves on a read, so it doubles as the response holding register.
   assign rsp_inst  = (have_data_q && !err_q) ? rd_data : INST_ERR_FILL;
   assign rsp_err   = err_q;
   assign rsp_valid = rsp_valid_q;
   assign req_ready = req_ready_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - scoreboard bench for imem_responder at LATENCY 1..4
module tb_imem_responder;

   localparam int N = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst       [N];
   logic        req_valid [N];
   logic [31:0] req_addr  [N];
   logic        rsp_ready [N];
   logic        load_en   [N];
   logic [31:0] load_addr [N];
   logic [31:0] load_data [N];
   logic        req_ready_w [N];
   logic        rsp_valid_w [N];
   logic        rsp_err_w   [N];
   logic        busy_w      [N];
   logic [31:0] rsp_inst_w  [N];

   typedef struct packed {
      logic [31:0] inst;
      logic        err;
      logic [31:0] rise;
   } exp_t;

   exp_t        exp_q [N][$];
   int          errors = 0;
   int          checks = 0;
   logic [31:0] cyc = 32'd0;
   logic [31:0] acc_cyc = 32'd0;

   always @(posedge clk) cyc <= cyc + 32'd1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   generate
      for (genvar g = 0; g < N; g++) begin : g_dut
         imem_responder #(
            .BASE_ADDR  (32'h8000_0000),
            .DEPTH_WORDS(4096),
            .LATENCY    (g + 1)
         ) dut (
            .clk      (clk),
            .rst      (rst[g]),
            .req_valid(req_valid[g]),
            .req_ready(req_ready_w[g]),
            .req_addr (req_addr[g]),
            .rsp_valid(rsp_valid_w[g]),
            .rsp_ready(rsp_ready[g]),
            .rsp_inst (rsp_inst_w[g]),
            .rsp_err  (rsp_err_w[g]),
            .load_en  (load_en[g]),
            .load_addr(load_addr[g]),
            .load_data(load_data[g]),
            .busy     (busy_w[g])
         );

         logic        prev_v = 1'b0;
         logic [32:0] last   = '0;
         exp_t        e;

         always @(negedge clk) begin
            if (rst[g]) begin
               prev_v = 1'b0;
            end else begin
               if (rsp_valid_w[g] && !prev_v) begin
                  if (exp_q[g].size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_rsp[%0d]: got rsp_valid=1 required none", g);
                  end else begin
                     e = exp_q[g].pop_front();
                     check($sformatf("rsp_inst[%0d]", g), rsp_inst_w[g], e.inst);
                     check($sformatf("rsp_err[%0d]", g), {31'b0, rsp_err_w[g]}, {31'b0, e.err});
                     check($sformatf("rsp_cycle[%0d]", g), cyc, e.rise);
                  end
                  last = {rsp_err_w[g], rsp_inst_w[g]};
               end else if (rsp_valid_w[g]) begin
                  check($sformatf("hold_inst[%0d]", g), rsp_inst_w[g], last[31:0]);
                  check($sformatf("hold_err[%0d]", g), {31'b0, rsp_err_w[g]}, {31'b0, last[32]});
               end
               prev_v = rsp_valid_w[g];
            end
         end
      end
   endgenerate

   // All tasks are entered and left on a falling edge.
   task automatic load(input int i, input logic [31:0] a, input logic [31:0] d);
      load_en[i] = 1'b1;
      load_addr[i] = a;
      load_data[i] = d;
      @(negedge clk);
      load_en[i] = 1'b0;
   endtask

   task automatic fetch(input int i, input logic [31:0] a, input logic [31:0] inst, input logic err);
      int n = 0;
      req_valid[i] = 1'b1;
      req_addr[i]  = a;
      while (!req_ready_w[i] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready_w[i]) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout[%0d]: got req_ready=0 required 1", i);
         req_valid[i] = 1'b0;
      end else begin
         acc_cyc = cyc + 32'd1;
         exp_q[i].push_back('{inst: inst, err: err, rise: cyc + 32'(i + 1)});
         @(negedge clk);
         req_valid[i] = 1'b0;
      end
   endtask

   task automatic drain(input int i);
      int n = 0;
      while (exp_q[i].size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check($sformatf("drain[%0d]", i), 32'(exp_q[i].size()), 32'd0);
      exp_q[i].delete();
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] prev_acc;
      int          n;
      for (int i = 0; i < N; i++) begin
         rst[i] = 1'b1;
         req_valid[i] = 1'b0;
         req_addr[i] = 32'h0;
         rsp_ready[i] = 1'b1;
         load_en[i] = 1'b0;
         load_addr[i] = 32'h0;
         load_data[i] = 32'h0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < N; i++) rst[i] = 1'b0;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         check($sformatf("rst_req_ready[%0d]", i), {31'b0, req_ready_w[i]}, 32'd1);
         check($sformatf("rst_rsp_valid[%0d]", i), {31'b0, rsp_valid_w[i]}, 32'd0);
         check($sformatf("rst_rsp_inst[%0d]", i), rsp_inst_w[i], 32'h0);
         check($sformatf("rst_rsp_err[%0d]", i), {31'b0, rsp_err_w[i]}, 32'd0);
         check($sformatf("rst_busy[%0d]", i), {31'b0, busy_w[i]}, 32'd0);
      end

      // 1: LATENCY=1 basic fetch
      load(0, 32'h8000_0000, 32'h0000_0413);
      fetch(0, 32'h8000_0000, 32'h0000_0413, 1'b0);
      check("t1_req_ready_low", {31'b0, req_ready_w[0]}, 32'd0);
      check("t1_rsp_valid", {31'b0, rsp_valid_w[0]}, 32'd1);
      drain(0);

      // 2: LATENCY=3 with a 4-cycle stall and a load to the same word during it
      rsp_ready[2] = 1'b0;
      load(2, 32'h8000_0004, 32'h0010_0073);
      fetch(2, 32'h8000_0004, 32'h0010_0073, 1'b0);
      n = 0;
      while (!rsp_valid_w[2] && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("t2_rsp_valid_seen", {31'b0, rsp_valid_w[2]}, 32'd1);
      load(2, 32'h8000_0004, 32'h1234_5678);
      for (int k = 0; k < 3; k++) begin
         check("t2_stall_inst", rsp_inst_w[2], 32'h0010_0073);
         @(negedge clk);
      end
      check("t2_stall_inst_last", rsp_inst_w[2], 32'h0010_0073);
      rsp_ready[2] = 1'b1;
      @(negedge clk);
      check("t2_idle_valid", {31'b0, rsp_valid_w[2]}, 32'd0);
      check("t2_idle_busy", {31'b0, busy_w[2]}, 32'd0);
      check("t2_idle_ready", {31'b0, req_ready_w[2]}, 32'd1);
      check("t2_inst_kept", rsp_inst_w[2], 32'h0010_0073);
      fetch(2, 32'h8000_0004, 32'h1234_5678, 1'b0);
      drain(2);

      // 3: misaligned / out-of-range fetches and ignored backdoor loads
      fetch(0, 32'h8000_0002, 32'h0, 1'b1);
      fetch(0, 32'h7FFF_FFFC, 32'h0, 1'b1);
      fetch(0, 32'h8000_4000, 32'h0, 1'b1);
      load(0, 32'h8000_3FFC, 32'hCAFE_F00D);
      fetch(0, 32'h8000_3FFC, 32'hCAFE_F00D, 1'b0);
      load(0, 32'h8000_4000, 32'hBAD0_BAD0);
      load(0, 32'h8000_0001, 32'hBAD1_BAD1);
      fetch(0, 32'h8000_0000, 32'h0000_0413, 1'b0);
      drain(0);

      // 4: same-edge load and accept returns the old word
      load(0, 32'h8000_0008, 32'h1111_1111);
      check("t4_ready", {31'b0, req_ready_w[0]}, 32'd1);
      load_en[0] = 1'b1;
      load_addr[0] = 32'h8000_0008;
      load_data[0] = 32'hDEAD_BEEF;
      req_valid[0] = 1'b1;
      req_addr[0] = 32'h8000_0008;
      exp_q[0].push_back('{inst: 32'h1111_1111, err: 1'b0, rise: cyc + 32'd1});
      @(negedge clk);
      load_en[0] = 1'b0;
      req_valid[0] = 1'b0;
      drain(0);
      fetch(0, 32'h8000_0008, 32'hDEAD_BEEF, 1'b0);
      drain(0);

      // 5: LATENCY=4, reset while in flight
      load(3, 32'h8000_0010, 32'h55AA_55AA);
      fetch(3, 32'h8000_0010, 32'h55AA_55AA, 1'b0);
      @(negedge clk);
      rst[3] = 1'b1;
      exp_q[3].delete();
      repeat (2) @(negedge clk);
      rst[3] = 1'b0;
      @(negedge clk);
      check("t5_req_ready", {31'b0, req_ready_w[3]}, 32'd1);
      check("t5_rsp_valid", {31'b0, rsp_valid_w[3]}, 32'd0);
      check("t5_busy", {31'b0, busy_w[3]}, 32'd0);
      repeat (6) @(negedge clk);
      fetch(3, 32'h8000_0010, 32'h55AA_55AA, 1'b0);
      drain(3);

      // 6: LATENCY=2 back-to-back, one accept every 3 cycles
      for (int k = 0; k < 16; k++) load(1, 32'h8000_0000 + 32'(4 * k), 32'hA5A5_0000 + 32'(k));
      prev_acc = 32'd0;
      for (int k = 0; k < 16; k++) begin
         fetch(1, 32'h8000_0000 + 32'(4 * k), 32'hA5A5_0000 + 32'(k), 1'b0);
         if (k > 0) check("t6_period", acc_cyc - prev_acc, 32'd3);
         prev_acc = acc_cyc;
      end
      drain(1);

      for (int i = 0; i < N; i++) drain(i);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder at the fetch end of the core's pc/inst interface.
- The core drives a fetch address; this block returns the 32-bit instruction word from a word-organised RAM through a valid/ready request/response handshake with a configurable latency.
- Also provides a backdoor load port so the simulation harness can preload program images.
- Decodes misaligned and out-of-range fetches to an error response.

Parameters:
- BASE_ADDR, 32'h80000000, byte address of word 0 (the core's reset pc)
- DEPTH_WORDS, 4096, number of 32-bit words; power of two
- LATENCY, 1, cycles from request accept edge to rsp_valid; legal range 1..8

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  fetch request valid
- req_ready  out  1  block can accept a request
- req_addr  in  32  fetch byte address (pc)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  core accepts response
- rsp_inst  out  32  fetched instruction word
- rsp_err  out  1  fetch fault (misaligned or out of range)
- load_en  in  1  backdoor word write enable
- load_addr  in  32  backdoor byte address
- load_data  in  32  backdoor write data
- busy  out  1  a request is in flight (state != IDLE)

Behaviour:
- Reset (async assert, sync release): state=IDLE, req_ready=1, rsp_valid=0, rsp_inst=0, rsp_err=0, busy=0, latency counter=0. RAM contents are not cleared.
- Reset mid-operation drops any in-flight request silently. No response is produced for it.
- States:
  - IDLE: req_ready=1.
  - WAIT: counting latency.
  - RESP: rsp_valid=1, held until accepted.
- Accept occurs at a rising edge with req_valid && req_ready.
- Address check at accept: idx=(req_addr-BASE_ADDR)>>2, 32-bit unsigned subtraction (wrap below BASE_ADDR makes idx huge).
  - err = (req_addr[1:0]!=0) || (req_addr-BASE_ADDR >= DEPTH_WORDS*4).
- Data capture: RAM read is performed at the accept edge into a holding register. Later load_en writes, even to the same word, do not change that response.
- On err, the holding register is 32'h00000000 and rsp_err=1. The RAM is not read.
- Transitions:
  - IDLE->RESP on accept when LATENCY==1.
  - IDLE->WAIT on accept when LATENCY>1, with cnt=LATENCY-1.
  - WAIT: cnt decrements each cycle. At cnt==1 the next edge moves to RESP.
- rsp_valid rises exactly LATENCY edges after the accept edge.
- RESP:
  - rsp_inst and rsp_err are stable while rsp_valid && !rsp_ready.
  - On the rsp_ready edge: go to IDLE, rsp_valid=0, rsp_inst/rsp_err keep their last value.
- Single outstanding request. req_ready=0 in WAIT and RESP. Peak throughput is one fetch per LATENCY+1 cycles.
- Request stability: the core holds req_addr stable while req_valid && !req_ready. The block samples req_addr only on the accept edge.
- Backdoor load:
  - Synchronous write on the edge with load_en.
  - Misaligned or out-of-range load_addr is ignored; no write occurs.
  - Accepted in any state.
  - Same-edge load and accept to the same word: the accept returns the OLD data (read-before-write).
- ebreak word 32'h00100073 is not special here; it is returned like any data.

Decomposition:
- Package imem_pkg:
  - state enum {IDLE, WAIT, RESP}
  - INST_ERR_FILL = 32'h00000000
  - helper function addr_in_range(addr, base, depth)
- Sub-module imem_array (DEPTH_WORDS x 32, one sync read port with read enable, one sync write port, read-before-write). It holds the storage only; the FSM, latency counter and address decode stay in imem_responder.

Test Plan:
1. Reset release, preload 0x80000000<=32'h00000413, LATENCY=1. Request 0x80000000 -> req_ready low next cycle, rsp_valid 1 cycle after accept, rsp_inst=32'h00000413, rsp_err=0.
2. LATENCY=3, rsp_ready held low 4 cycles after rsp_valid. Request 0x80000004 preloaded 32'h00100073 -> rsp_valid 3 edges after accept, rsp_inst stays 32'h00100073 while stalled, IDLE one cycle after the rsp_ready handshake.
3. Request 0x80000002 -> rsp_err=1, rsp_inst=0. Request 0x7FFFFFFC -> rsp_err=1. Request BASE_ADDR+DEPTH_WORDS*4 -> rsp_err=1. Last word BASE+DEPTH*4-4 -> rsp_err=0 with its data.
4. Same-edge load_en to 0x80000008 (new 32'hDEADBEEF, old 32'h11111111) and accept of 0x80000008 -> rsp_inst=32'h11111111. A following fetch returns 32'hDEADBEEF.
5. LATENCY=4, assert rst 2 cycles after accept -> rsp_valid never rises, req_ready=1 after release, next fetch returns correct data.
6. Back-to-back fetches 0x80000000..0x8000003C with rsp_ready tied 1, LATENCY=2 -> 16 responses in order, one per 3 cycles, data matches preload.
